// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register-file word/index types and the write-request record.
package cpu_types_pkg;
    localparam int REG_COUNT = 32;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef struct packed {
        regbits_t wsel;
        word_t    wdat;
    } rf_wr_t;

    // One-hot decode of a register index into a REG_COUNT-wide bitmap.
    function automatic logic [REG_COUNT-1:0] reg_decode(input regbits_t r);
        return {{(REG_COUNT-1){1'b0}}, 1'b1} << r;
    endfunction
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback-side bundle: two requester handshakes, drain hold, register-file write port and status.
interface rf_wb_arbiter_if #(
    parameter int DEPTH = 2
) ();
    logic                            req0_valid;
    cpu_types_pkg::regbits_t         req0_wsel;
    cpu_types_pkg::word_t            req0_wdat;
    logic                            req0_ready;
    logic                            req1_valid;
    cpu_types_pkg::regbits_t         req1_wsel;
    cpu_types_pkg::word_t            req1_wdat;
    logic                            req1_ready;
    logic                            hold;
    logic                            rf_WEN;
    cpu_types_pkg::regbits_t         rf_wsel;
    cpu_types_pkg::word_t            rf_wdat;
    logic [cpu_types_pkg::REG_COUNT-1:0] pending;
    logic [$clog2(DEPTH):0]          count;

    modport slave (
        input  req0_valid, req0_wsel, req0_wdat,
        input  req1_valid, req1_wsel, req1_wdat,
        input  hold,
        output req0_ready, req1_ready,
        output rf_WEN, rf_wsel, rf_wdat, pending, count
    );

    modport master (
        output req0_valid, req0_wsel, req0_wdat,
        output req1_valid, req1_wsel, req1_wdat,
        output hold,
        input  req0_ready, req1_ready,
        input  rf_WEN, rf_wsel, rf_wdat, pending, count
    );
endinterface

// File: rtl/rf_wr_fifo.sv
// In-order queue of register-file writes with a combinational head and a per-entry valid/wsel view.
module rf_wr_fifo
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  rf_wr_t                   push_data,
    input  logic                     pop,
    output rf_wr_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DEPTH-1:0]         entry_valid,
    output regbits_t [DEPTH-1:0]     entry_wsel
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    rf_wr_t        mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [DEPTH-1:0] valid_reg;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg];
    assign count   = count_reg;
    assign entry_valid = valid_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Push and pop never hit the same slot: that needs count==0 or count==DEPTH, where one is blocked.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign entry_wsel[gi] = mem_reg[gi].wsel;

        always_ff @(posedge clk) begin
            if (srst) begin
                valid_reg[gi] <= 1'b0;
            end else if (do_push && wr_ptr_reg == AW'(gi)) begin
                valid_reg[gi] <= 1'b1;
            end else if (do_pop && rd_ptr_reg == AW'(gi)) begin
                valid_reg[gi] <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two writeback requesters via a write queue.
module rf_wb_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RST,
    rf_wb_arbiter_if.slave    bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 rr_reg;
    logic                 grant0;
    logic                 grant1;
    logic                 space;
    logic                 accept0;
    logic                 accept1;
    logic                 push;
    logic                 drain;
    rf_wr_t               acc_wr;
    rf_wr_t               head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [DEPTH-1:0]     entry_valid;
    regbits_t [DEPTH-1:0] entry_wsel;
    logic [REG_COUNT-1:0] pend_term [DEPTH];
    logic [REG_COUNT-1:0] pend_all;

    // No pass-through: a full queue refuses writes even on a cycle that drains.
    always_comb begin
        grant0      = bus.req0_valid && (!bus.req1_valid || !rr_reg);
        grant1      = bus.req1_valid && (!bus.req0_valid ||  rr_reg);
        space       = !fifo_full && !RST;
        accept0     = grant0 && space;
        accept1     = grant1 && space;
        acc_wr.wsel = accept1 ? bus.req1_wsel : bus.req0_wsel;
        acc_wr.wdat = accept1 ? bus.req1_wdat : bus.req0_wdat;
        push        = (accept0 || accept1) && (acc_wr.wsel != '0);
        drain       = !fifo_empty && !bus.hold && !RST;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_reg <= 1'b0;
        end else if (accept0) begin
            rr_reg <= 1'b1;
        end else if (accept1) begin
            rr_reg <= 1'b0;
        end
    end

    rf_wr_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .srst       (RST),
        .push       (push),
        .push_data  (acc_wr),
        .pop        (drain),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .entry_valid(entry_valid),
        .entry_wsel (entry_wsel)
    );

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
        assign pend_term[gi] = entry_valid[gi] ? reg_decode(entry_wsel[gi]) : '0;
    end

    always_comb begin
        pend_all = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_all = pend_all | pend_term[i];
        end
    end

    assign bus.req0_ready = accept0;
    assign bus.req1_ready = accept1;
    assign bus.rf_WEN     = drain;
    assign bus.rf_wsel    = drain ? head.wsel : '0;
    assign bus.rf_wdat    = drain ? head.wdat : '0;
    assign bus.pending    = RST ? '0 : (pend_all & ~{{(REG_COUNT-1){1'b0}}, 1'b1});
    assign bus.count      = fifo_count;
endmodule
